// File: rtl/vin_pattern_gen_if.sv
// vin_pattern_gen_if: video bus from the internal pattern source.
// Carries sync, data enable, pixel lanes and frame markers.
interface vin_pattern_gen_if #(
  parameter int PIX_W = 8,
  parameter int PPC   = 2
);
  logic                   v_vsync;
  logic                   v_hsync;
  logic                   v_de;
  logic [PIX_W*PPC-1:0]   v_pixel;
  logic                   frame_start;
  logic [15:0]            frame_count;

  modport master (
    output v_vsync,
    output v_hsync,
    output v_de,
    output v_pixel,
    output frame_start,
    output frame_count
  );

  modport slave (
    input v_vsync,
    input v_hsync,
    input v_de,
    input v_pixel,
    input frame_start,
    input frame_count
  );
endinterface

// File: rtl/vin_pattern_gen.sv
// vin_pattern_gen: internal DE/HS/VS video source with test patterns.
// Timing comes from compile-time porch/active values; outputs registered.
module vin_pattern_gen #(
  parameter int PIX_W     = 8,
  parameter int PPC       = 2,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 152,
  parameter int H_ACT     = 800,
  parameter int H_FP      = 32,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 46,
  parameter int V_ACT     = 1200,
  parameter int V_FP      = 1,
  parameter bit SYNC_POL  = 1'b1,
  parameter int BAR_W     = 200,
  parameter int CHK_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [PIX_W-1:0] fg,
  vin_pattern_gen_if.master vid
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [15:0] H_SYNC_C = 16'(H_SYNC);
  localparam logic [15:0] H_AS_C   = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_AE_C   = 16'(H_SYNC + H_BP + H_ACT);
  localparam logic [15:0] H_LAST_C = 16'(H_TOT - 1);
  localparam logic [15:0] V_SYNC_C = 16'(V_SYNC);
  localparam logic [15:0] V_AS_C   = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_AE_C   = 16'(V_SYNC + V_BP + V_ACT);
  localparam logic [15:0] V_LAST_C = 16'(V_TOT - 1);
  localparam logic [15:0] PPC_C    = 16'(PPC);
  localparam logic [15:0] BAR_W_C  = 16'(BAR_W);
  localparam logic [31:0] X_LAST_C = 32'(H_ACT * PPC - 1);
  localparam logic [31:0] Y_LAST_C = 32'(V_ACT - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e state_q, state_d;

  logic [15:0] h_q, h_d;
  logic [15:0] v_q, v_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] bpos_q, bpos_d;
  logic [2:0]  bidx_q, bidx_d;

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;
  logic fs_q, fs_d;
  logic [PIX_W*PPC-1:0] pix_q, pix_d;

  logic        run;
  logic        sof;
  logic        h_act;
  logic        v_act;
  logic        de_now;
  logic [2:0]  mode_eff;
  logic [15:0] fc_eff;
  logic [31:0] xs;
  logic [31:0] ys;
  logic [31:0] xk;
  logic [2:0]  bk;
  logic [PIX_W-1:0] lane;

  // Decode the current raster position and frame-start context.
  always_comb begin
    run      = (state_q == S_RUN) && enable;
    sof      = run && (h_q == '0) && (v_q == '0);
    h_act    = (h_q >= H_AS_C) && (h_q < H_AE_C);
    v_act    = (v_q >= V_AS_C) && (v_q < V_AE_C);
    de_now   = run && h_act && v_act;
    mode_eff = sof ? mode : mode_q;
    fc_eff   = sof ? fc_q + 16'd1 : fc_q;
  end

  // Run/idle control and raster counters; mode latched per frame.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
          h_d     = '0;
          v_d     = '0;
          mode_d  = mode;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
          h_d     = '0;
          v_d     = '0;
        end else begin
          if (sof) begin
            mode_d = mode;
          end
          if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + 16'd1;
          end else begin
            h_d = h_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame counter counts every frame start while running.
  always_comb begin
    fc_d = sof ? fc_q + 16'd1 : fc_q;
  end

  // Per-line bar tracker: pixel offset in bar and bar index for lane 0.
  always_comb begin
    bpos_d = '0;
    bidx_d = '0;
    if (run && h_act && (h_q != H_LAST_C)) begin
      if (bpos_q + PPC_C >= BAR_W_C) begin
        bpos_d = bpos_q + PPC_C - BAR_W_C;
        bidx_d = bidx_q + 3'd1;
      end else begin
        bpos_d = bpos_q + PPC_C;
        bidx_d = bidx_q;
      end
    end
  end

  // Sync/DE levels and per-lane pattern data for the next output cycle.
  always_comb begin
    hs_d  = (run && (h_q < H_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (run && (v_q < V_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
    de_d  = de_now;
    fs_d  = sof;
    pix_d = '0;
    xs    = 32'(h_q - H_AS_C) * 32'(PPC);
    ys    = 32'(v_q - V_AS_C);
    xk    = '0;
    bk    = '0;
    lane  = '0;
    for (int k = 0; k < PPC; k++) begin
      xk   = xs + 32'(k);
      bk   = (bpos_q + 16'(k) >= BAR_W_C) ? bidx_q + 3'd1 : bidx_q;
      lane = '0;
      unique case (mode_eff)
        3'd0: lane = fg;
        3'd1: lane = PIX_W'(xk);
        3'd2: lane[PIX_W-1 -: 3] = bk;
        3'd3: lane = (xk[CHK_SHIFT] ^ ys[CHK_SHIFT]) ? ~fg : fg;
        3'd4: lane = PIX_W'(xk + 32'(fc_eff));
        3'd5: begin
          if ((xk == '0) || (xk == X_LAST_C) ||
              (ys == '0) || (ys == Y_LAST_C)) begin
            lane = fg;
          end
        end
        default: lane = '0;
      endcase
      if (de_now) begin
        pix_d[k*PIX_W +: PIX_W] = lane;
      end
    end
  end

  // State and output registers; reset forces idle bus levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= '0;
      fc_q    <= '0;
      bpos_q  <= '0;
      bidx_q  <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      fc_q    <= fc_d;
      bpos_q  <= bpos_d;
      bidx_q  <= bidx_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      pix_q   <= pix_d;
    end
  end

  assign vid.v_vsync     = vs_q;
  assign vid.v_hsync     = hs_q;
  assign vid.v_de        = de_q;
  assign vid.v_pixel     = pix_q;
  assign vid.frame_start = fs_q;
  assign vid.frame_count = fc_q;

endmodule

// File: tb/tb_vin_pattern_gen.sv
// tb_vin_pattern_gen: randomized check of the pattern generator
// against a frame-time arithmetic reference model.
module tb_vin_pattern_gen;

  localparam int PIX_W = 8;
  localparam int PPC   = 2;
  localparam int HS = 2, HB = 2, HA = 4, HF = 2;
  localparam int VS = 1, VB = 1, VA = 2, VF = 1;
  localparam int H_TOT = HS + HB + HA + HF;
  localparam int V_TOT = VS + VB + VA + VF;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int BAR_W = 3;
  localparam int CHK   = 1;
  localparam bit SP    = 1'b1;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [15:0] pix;
    logic        fs;
    logic [15:0] fc;
  } out_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [2:0]       mode = '0;
  logic [PIX_W-1:0] fg = '0;

  int vec = 0;
  int err = 0;

  vin_pattern_gen_if #(.PIX_W(PIX_W), .PPC(PPC)) vif ();

  vin_pattern_gen #(
    .PIX_W(PIX_W), .PPC(PPC),
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .SYNC_POL(SP), .BAR_W(BAR_W), .CHK_SHIFT(CHK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode(mode),
    .fg(fg),
    .vid(vif)
  );

  always #5 clk = ~clk;

  out_t d_out;
  assign d_out = {vif.v_vsync, vif.v_hsync, vif.v_de, vif.v_pixel,
                  vif.frame_start, vif.frame_count};

  function automatic out_t idle_out(logic [15:0] fc);
    out_t o;
    o    = '0;
    o.vs = ~SP;
    o.hs = ~SP;
    o.fc = fc;
    return o;
  endfunction

  function automatic out_t run_out(int pos, logic [2:0] md,
                                   logic [7:0] f, logic [15:0] fc);
    out_t o;
    int h, v, x, y, b;
    logic [7:0] p;
    h    = pos % H_TOT;
    v    = pos / H_TOT;
    o    = '0;
    o.vs = (v < VS) ? SP : ~SP;
    o.hs = (h < HS) ? SP : ~SP;
    o.fs = (pos == 0);
    o.fc = fc;
    o.de = (h >= HS + HB) && (h < HS + HB + HA) &&
           (v >= VS + VB) && (v < VS + VB + VA);
    if (o.de) begin
      for (int k = 0; k < PPC; k++) begin
        x = (h - HS - HB) * PPC + k;
        y = v - VS - VB;
        case (md)
          3'd0: p = f;
          3'd1: p = 8'(x);
          3'd2: begin
            b = (x / BAR_W) % 8;
            p = 8'(b * 32);
          end
          3'd3: p = (((x >> CHK) ^ (y >> CHK)) & 1) != 0 ? ~f : f;
          3'd4: p = 8'(x + int'(fc));
          3'd5: p = (x == 0 || x == HA * PPC - 1 ||
                     y == 0 || y == VA - 1) ? f : 8'h00;
          default: p = 8'h00;
        endcase
        o.pix[k*8 +: 8] = p;
      end
    end
    return o;
  endfunction

  // Reference: position in frame is the number of running cycles mod FRAME.
  logic        m_run;
  int          m_t;
  logic [2:0]  m_mode;
  logic [15:0] m_fc;
  out_t        e_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  <= 1'b0;
      m_t    <= 0;
      m_mode <= '0;
      m_fc   <= '0;
      e_out  <= idle_out(16'd0);
    end else if (!m_run) begin
      if (enable) begin
        m_run  <= 1'b1;
        m_t    <= 0;
        m_mode <= mode;
      end
      e_out <= idle_out(m_fc);
    end else if (!enable) begin
      m_run <= 1'b0;
      e_out <= idle_out(m_fc);
    end else begin
      m_t <= m_t + 1;
      if (m_t % FRAME == 0) begin
        m_mode <= mode;
        m_fc   <= m_fc + 16'd1;
        e_out  <= run_out(0, mode, fg, m_fc + 16'd1);
      end else begin
        e_out <= run_out(m_t % FRAME, m_mode, fg, m_fc);
      end
    end
  end

  task automatic do_reset();
    enable = 1'b0;
    mode   = '0;
    fg     = '0;
    rst    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (200) begin
      @(negedge clk);
      vec++;
      if (d_out !== idle_out(16'd0)) begin
        err++;
        $display("FAIL reset_idle got=%h exp=%h", d_out, idle_out(16'd0));
      end
    end
  endtask

  task automatic test_timing();
    int nfs, nvs, nhs, nde;
    do_reset();
    fg     = 8'($urandom);
    enable = 1'b1;
    nfs = 0; nvs = 0; nhs = 0; nde = 0;
    for (int c = 1; c <= 151; c++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL timing_model cyc=%0d got=%h exp=%h", c, d_out, e_out);
      end
      if (vif.frame_start) begin
        vec++;
        if (c != 2 + 50 * nfs) begin
          err++;
          $display("FAIL timing_fs_cycle got=%0d exp=%0d", c, 2 + 50 * nfs);
        end
        vec++;
        if (vif.frame_count !== 16'(nfs + 1)) begin
          err++;
          $display("FAIL timing_fc got=%0d exp=%0d", vif.frame_count, nfs + 1);
        end
        nfs++;
      end
      nvs += int'(vif.v_vsync);
      nhs += int'(vif.v_hsync);
      nde += int'(vif.v_de);
    end
    vec++;
    if (nfs != 3) begin
      err++;
      $display("FAIL timing_nfs got=%0d exp=3", nfs);
    end
    vec++;
    if (nvs != 30) begin
      err++;
      $display("FAIL timing_vsync got=%0d exp=30", nvs);
    end
    vec++;
    if (nhs != 30) begin
      err++;
      $display("FAIL timing_hsync got=%0d exp=30", nhs);
    end
    vec++;
    if (nde != 24) begin
      err++;
      $display("FAIL timing_de got=%0d exp=24", nde);
    end
    enable = 1'b0;
  endtask

  task automatic test_gradient();
    int nde;
    logic [15:0] w;
    do_reset();
    mode   = 3'd1;
    fg     = 8'($urandom);
    enable = 1'b1;
    nde = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL gradient_model cyc=%0d got=%h exp=%h", c, d_out, e_out);
      end
      if (vif.v_de) begin
        w = {8'(2 * (nde % 4) + 1), 8'(2 * (nde % 4))};
        vec++;
        if (vif.v_pixel !== w) begin
          err++;
          $display("FAIL gradient_word got=%h exp=%h", vif.v_pixel, w);
        end
        nde++;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_mode_latch();
    int nde;
    logic [15:0] w;
    do_reset();
    mode   = 3'd0;
    fg     = 8'hAA;
    enable = 1'b1;
    nde = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL latch_model cyc=%0d got=%h exp=%h", c, d_out, e_out);
      end
      if (vif.v_de) begin
        if (nde < 8) w = 16'hAAAA;
        else w = {8'(2 * (nde % 4) + 1), 8'(2 * (nde % 4))};
        vec++;
        if (vif.v_pixel !== w) begin
          err++;
          $display("FAIL latch_word n=%0d got=%h exp=%h", nde, vif.v_pixel, w);
        end
        nde++;
        if (nde == 1) mode = 3'd1;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_moving_checker();
    bit armed, seen;
    int nde;
    logic [15:0] w;
    do_reset();
    fg     = 8'($urandom);
    enable = 1'b1;
    armed = 1'b0;
    seen  = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL moving_model cyc=%0d got=%h exp=%h", c, d_out, e_out);
      end
      if (vif.frame_start && vif.frame_count == 16'd2) mode = 3'd4;
      if (vif.frame_start && vif.frame_count == 16'd3) armed = 1'b1;
      if (armed && vif.v_de) begin
        armed = 1'b0;
        seen  = 1'b1;
        vec++;
        if (vif.v_pixel !== 16'h0403) begin
          err++;
          $display("FAIL moving_first got=%h exp=0403", vif.v_pixel);
        end
      end
    end
    vec++;
    if (!seen) begin
      err++;
      $display("FAIL moving_seen got=0 exp=1");
    end
    do_reset();
    mode   = 3'd3;
    fg     = 8'h0F;
    enable = 1'b1;
    nde = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL checker_model cyc=%0d got=%h exp=%h", c, d_out, e_out);
      end
      if (vif.v_de) begin
        if (nde < 4) begin
          w = (nde % 2 == 0) ? 16'h0F0F : 16'hF0F0;
          vec++;
          if (vif.v_pixel !== w) begin
            err++;
            $display("FAIL checker_row0 n=%0d got=%h exp=%h", nde, vif.v_pixel, w);
          end
        end
        nde++;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_abort();
    out_t idle1;
    do_reset();
    mode   = 3'($urandom_range(0, 5));
    fg     = 8'($urandom);
    enable = 1'b1;
    idle1  = idle_out(16'd1);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL abort_model cyc=%0d got=%h exp=%h", c, d_out, e_out);
      end
      if (c == 37) begin
        vec++;
        if (d_out !== idle1) begin
          err++;
          $display("FAIL abort_idle got=%h exp=%h", d_out, idle1);
        end
      end
      if (c == 42) begin
        vec++;
        if (vif.frame_start !== 1'b1 || vif.frame_count !== 16'd2) begin
          err++;
          $display("FAIL abort_restart got=%b/%0d exp=1/2",
                   vif.frame_start, vif.frame_count);
        end
      end
      if (c == 36) enable = 1'b0;
      if (c == 40) enable = 1'b1;
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      vec++;
      if (d_out !== e_out) begin
        err++;
        $display("FAIL random_model i=%0d got=%h exp=%h", i, d_out, e_out);
      end
      if (i == 1500) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vec++;
        if (d_out !== idle_out(16'd0)) begin
          err++;
          $display("FAIL async_rst got=%h exp=%h", d_out, idle_out(16'd0));
        end
        @(negedge clk);
        rst = 1'b0;
      end
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) mode = 3'($urandom);
      if ($urandom_range(0, 7) == 0) fg = 8'($urandom);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_gradient();
    test_mode_latch();
    test_moving_checker();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
